// File: rtl/launch_interval_timer.sv
// Multi-channel sync-to-launch interval timer: measures Clk100MHz cycles from a SynchrM
// rising edge to the first rising edge on each LaunchM line, publishing saturated results atomically.
module launch_interval_timer #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 127,
    parameter int EARLY_DONE = 0
) (
    input  logic                    Clk100MHz,
    input  logic                    nReset,
    input  logic                    SynchrM,
    input  logic [N_CH-1:0]         LaunchM,
    output logic [N_CH*CNT_W-1:0]   ResultTimer,
    output logic [N_CH-1:0]         ResultTimeout,
    output logic [N_CH-1:0]         ResultDup,
    output logic                    ResultStrobe,
    output logic                    Busy,
    output logic                    Restarted
);

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t state, stateNext;

    logic                        syncS1, syncS2, syncS3;
    logic [N_CH-1:0]             launchS1, launchS2, launchS3;
    logic                        syncEdge;
    logic [N_CH-1:0]             launchEdge;

    logic [CNT_W-1:0]            count;
    logic [N_CH-1:0][CNT_W-1:0]  cap, capNext;
    logic [N_CH-1:0]             got, gotNext;
    logic [N_CH-1:0]             dup, dupNext;
    logic                        captureEn;
    logic                        publish;
    logic [N_CH-1:0][CNT_W-1:0]  resultReg;

    // Two-FF synchronisers plus a delay stage for rising-edge detection.
    always_ff @(posedge Clk100MHz or negedge nReset) begin
        if (!nReset) begin
            syncS1   <= 1'b0;
            syncS2   <= 1'b0;
            syncS3   <= 1'b0;
            launchS1 <= '0;
            launchS2 <= '0;
            launchS3 <= '0;
        end else begin
            syncS1   <= SynchrM;
            syncS2   <= syncS1;
            syncS3   <= syncS2;
            launchS1 <= LaunchM;
            launchS2 <= launchS1;
            launchS3 <= launchS2;
        end
    end

    assign syncEdge   = syncS2 & ~syncS3;
    assign launchEdge = launchS2 & ~launchS3;

    // A sync edge overrides both capture and publish in the same cycle.
    assign captureEn = (state == ARMED) && !syncEdge;

    always_comb begin
        capNext = cap;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (captureEn && launchEdge[i] && !got[i]) begin
                capNext[i] = count;
            end
        end
        gotNext = got | (launchEdge & {N_CH{captureEn}});
        dupNext = dup | (launchEdge & got & {N_CH{captureEn}});
    end

    assign publish = captureEn &&
                     ((count == TimeoutVal) || ((EARLY_DONE != 0) && (&gotNext)));

    always_ff @(posedge Clk100MHz or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (syncEdge) begin
            stateNext = ARMED;
        end else if (publish) begin
            stateNext = IDLE;
        end
    end

    always_comb begin
        Busy = (state == ARMED);
    end

    always_ff @(posedge Clk100MHz or negedge nReset) begin
        if (!nReset) begin
            count         <= '0;
            cap           <= '0;
            got           <= '0;
            dup           <= '0;
            resultReg     <= {N_CH{TimeoutVal}};
            ResultTimeout <= '1;
            ResultDup     <= '0;
            ResultStrobe  <= 1'b0;
            Restarted     <= 1'b0;
        end else begin
            ResultStrobe <= publish;
            Restarted    <= syncEdge && (state == ARMED);
            if (syncEdge) begin
                count <= '0;
                cap   <= '0;
                got   <= '0;
                dup   <= '0;
            end else if (state == ARMED) begin
                cap <= capNext;
                got <= gotNext;
                dup <= dupNext;
                if (count < TimeoutVal) begin
                    count <= count + CNT_W'(1);
                end
            end
            // Publish from the next-values so a capture in the final cycle is included.
            if (publish) begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    resultReg[i] <= gotNext[i] ? capNext[i] : TimeoutVal;
                end
                ResultTimeout <= ~gotNext;
                ResultDup     <= dupNext;
            end
        end
    end

    assign ResultTimer = resultReg;

endmodule

// File: tb/tb_launch_interval_timer.sv
// Directed bench for launch_interval_timer: table-driven windows plus restart,
// idle/coincident-launch and mid-window reset sequences.
module tb_launch_interval_timer;

    logic        clk;
    logic        rstN;
    logic        sync;
    logic [3:0]  launch;

    logic [31:0] timer0, timer1;
    logic [3:0]  to0, to1, dup0, dup1;
    logic        strobe0, strobe1, busy0, busy1, restart0, restart1;

    int errors = 0;
    int checks = 0;

    launch_interval_timer #(.N_CH(4), .CNT_W(8), .TIMEOUT(127), .EARLY_DONE(0)) dut0 (
        .Clk100MHz(clk), .nReset(rstN), .SynchrM(sync), .LaunchM(launch),
        .ResultTimer(timer0), .ResultTimeout(to0), .ResultDup(dup0),
        .ResultStrobe(strobe0), .Busy(busy0), .Restarted(restart0)
    );

    launch_interval_timer #(.N_CH(4), .CNT_W(8), .TIMEOUT(127), .EARLY_DONE(1)) dut1 (
        .Clk100MHz(clk), .nReset(rstN), .SynchrM(sync), .LaunchM(launch),
        .ResultTimer(timer1), .ResultTimeout(to1), .ResultDup(dup1),
        .ResultStrobe(strobe1), .Busy(busy1), .Restarted(restart1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch values are Count at capture, per channel {ch3,ch2,ch1,ch0}; 8'hFF = no launch.
    typedef struct {
        bit          early;
        logic [3:0][7:0] l1;
        logic [3:0][7:0] l2;
        logic [31:0] expTimer;
        logic [3:0]  expTo;
        logic [3:0]  expDup;
        int          expT;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit e, input logic [31:0] l1, input logic [31:0] l2,
                                input logic [31:0] tm, input logic [3:0] to,
                                input logic [3:0] dp, input int t);
        vec_t v;
        v.early = e;
        v.l1 = l1;
        v.l2 = l2;
        v.expTimer = tm;
        v.expTo = to;
        v.expDup = dp;
        v.expT = t;
        return v;
    endfunction

    // A line raised at negedge c+1 yields a capture with Count == c.
    function automatic bit hit(input logic [7:0] c, input int t);
        return (c != 8'hFF) && (t >= int'(c) + 1) && (t < int'(c) + 3);
    endfunction

    task automatic runVec(input vec_t v, input int idx);
        int strobes = 0;
        int strobeT = -1;
        logic busyPrev = 1'b0;
        logic busyAtStrobe = 1'b1;
        logic busyBefore = 1'b0;
        logic [31:0] tm = '0;
        logic [3:0] to = '0;
        logic [3:0] dp = '0;
        logic st, bz;
        for (int t = 0; t <= 150; t++) begin
            @(negedge clk);
            st = v.early ? strobe1 : strobe0;
            bz = v.early ? busy1 : busy0;
            if (st) begin
                strobes++;
                strobeT = t;
                tm = v.early ? timer1 : timer0;
                to = v.early ? to1 : to0;
                dp = v.early ? dup1 : dup0;
                busyAtStrobe = bz;
                busyBefore = busyPrev;
            end
            busyPrev = bz;
            sync = (t < 2);
            for (int c = 0; c < 4; c++) begin
                launch[c] = hit(v.l1[c], t) || hit(v.l2[c], t);
            end
        end
        chk($sformatf("vec%0d strobeCount", idx), 64'(strobes), 64'd1);
        chk($sformatf("vec%0d strobeTime", idx), 64'(strobeT), 64'(v.expT));
        chk($sformatf("vec%0d timer", idx), 64'(tm), 64'(v.expTimer));
        chk($sformatf("vec%0d timeout", idx), 64'(to), 64'(v.expTo));
        chk($sformatf("vec%0d dup", idx), 64'(dp), 64'(v.expDup));
        chk($sformatf("vec%0d busyAtStrobe", idx), 64'(busyAtStrobe), 64'd0);
        chk($sformatf("vec%0d busyBeforeStrobe", idx), 64'(busyBefore), 64'd1);
    endtask

    task automatic chkResetVals(input string tag);
        chk({tag, " timer0"}, 64'(timer0), 64'h7F7F7F7F);
        chk({tag, " to0"}, 64'(to0), 64'hF);
        chk({tag, " dup0"}, 64'(dup0), 64'h0);
        chk({tag, " flags0"}, 64'({strobe0, busy0, restart0}), 64'h0);
        chk({tag, " timer1"}, 64'(timer1), 64'h7F7F7F7F);
        chk({tag, " flags1"}, 64'({strobe1, busy1, restart1, to1, dup1}), 64'h0F0);
    endtask

    initial begin
        int strobes, strobeT, restarts, restartT, idleBad;
        logic [31:0] tm;
        logic [3:0] to, dp;

        vecs[0] = mk(1'b0, 32'hFF7E320A, 32'hFFFFFFFF, 32'h7F7E320A, 4'b1000, 4'b0000, 131);
        vecs[1] = mk(1'b1, 32'h14141414, 32'hFFFFFFFF, 32'h14141414, 4'b0000, 4'b0000, 24);
        vecs[2] = mk(1'b0, 32'hFF7F0500, 32'hFFFF1EFF, 32'h7F7F0500, 4'b1000, 4'b0010, 131);
        vecs[3] = mk(1'b1, 32'h28025A0F, 32'hFFFFFFFF, 32'h28025A0F, 4'b0000, 4'b0000, 94);
        vecs[4] = mk(1'b1, 32'hFF030405, 32'hFFFFFFFF, 32'h7F030405, 4'b1000, 4'b0000, 131);

        rstN = 1'b0;
        sync = 1'b0;
        launch = '0;
        repeat (3) @(negedge clk);
        chkResetVals("reset");
        rstN = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            runVec(vecs[i], i);
        end

        // Restart: second sync at Count=60, ch0 launches 7 cycles into the new window.
        strobes = 0; strobeT = -1; restarts = 0; restartT = -1;
        tm = '0; to = '0; dp = '1;
        for (int t = 0; t <= 200; t++) begin
            @(negedge clk);
            if (strobe0) begin
                strobes++; strobeT = t; tm = timer0; to = to0; dp = dup0;
            end
            if (restart0) begin
                restarts++; restartT = t;
            end
            sync = (t < 2) || (t >= 61 && t < 63);
            launch[0] = (t >= 11 && t < 13) || (t >= 69 && t < 71);
        end
        chk("restart count", 64'(restarts), 64'd1);
        chk("restart time", 64'(restartT), 64'd64);
        chk("restart strobeCount", 64'(strobes), 64'd1);
        chk("restart strobeTime", 64'(strobeT), 64'd192);
        chk("restart timer", 64'(tm), 64'h7F7F7F07);
        chk("restart timeout", 64'(to), 64'hE);
        chk("restart dup", 64'(dp), 64'h0);

        // Launch edges while IDLE are ignored.
        idleBad = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (strobe0 || busy0 || strobe1 || busy1) idleBad++;
            launch[3] = (t >= 2 && t < 4);
        end
        chk("idle launch activity", 64'(idleBad), 64'd0);

        // Launch on ch2 coincident with the sync edge is dropped; ch1 captures Count=3.
        strobes = 0; strobeT = -1; tm = '0; to = '0; dp = '1;
        for (int t = 0; t <= 150; t++) begin
            @(negedge clk);
            if (t == 100) chk("hold timer", 64'(timer0), 64'h7F7F7F07);
            if (strobe0) begin
                strobes++; strobeT = t; tm = timer0; to = to0; dp = dup0;
            end
            sync = (t < 2);
            launch[2] = (t < 2);
            launch[1] = (t >= 4 && t < 6);
        end
        chk("coinc strobeCount", 64'(strobes), 64'd1);
        chk("coinc strobeTime", 64'(strobeT), 64'd131);
        chk("coinc timer", 64'(tm), 64'h7F7F037F);
        chk("coinc timeout", 64'(to), 64'hD);
        chk("coinc dup", 64'(dp), 64'h0);
        chk("coinc timer early", 64'(timer1), 64'h7F7F037F);

        // Reset at Count=40 mid-window.
        for (int t = 0; t <= 43; t++) begin
            @(negedge clk);
            if (t == 43) chk("busy before reset", 64'(busy0), 64'd1);
            sync = (t < 2);
            launch[0] = (t >= 6 && t < 8);
        end
        rstN = 1'b0;
        #1;
        chkResetVals("midreset");
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        strobes = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (strobe0 || strobe1 || busy0 || busy1) strobes++;
        end
        chk("post-reset quiet", 64'(strobes), 64'd0);
        chk("post-reset timer", 64'(timer0), 64'h7F7F7F7F);

        runVec(vecs[1], 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/launch_interval_timer.md
Name: launch_interval_timer

Overview:
- Multi-channel successor to the single-channel sync-to-launch timer.
- Measures, in Clk100MHz cycles, the interval from the rising edge of the common SynchrM strobe to the first rising edge on each of N_CH LaunchM inputs.
- Results saturate at TIMEOUT and are published atomically with a one-cycle strobe.
- Sits between the external sync/launch lines and the result readout logic.

Parameters:
- N_CH, 4, number of launch channels (1..16)
- CNT_W, 8, counter and result width per channel
- TIMEOUT, 127, window length in cycles; TIMEOUT <= 2^CNT_W-1
- EARLY_DONE, 0, 1 = publish as soon as every channel has captured; 0 = always wait for TIMEOUT

Ports:
- Clk100MHz  in  1  system clock, all logic on posedge
- nReset  in  1  asynchronous active-low reset
- SynchrM  in  1  async sync strobe; rising edge opens a window
- LaunchM  in  N_CH  async launch lines, one per channel
- ResultTimer  out  N_CH*CNT_W  published intervals; channel i at [i*CNT_W +: CNT_W]
- ResultTimeout  out  N_CH  channel had no launch edge in the window
- ResultDup  out  N_CH  channel saw more than one launch edge in the window
- ResultStrobe  out  1  one-cycle pulse when results update
- Busy  out  1  window open (ARMED)
- Restarted  out  1  one-cycle pulse: sync edge arrived while ARMED

Behaviour:
- Reset (nReset low, async):
  - All synchroniser FFs, Count, captures and flags are 0.
  - State is IDLE.
  - ResultTimer is all ones, truncated to TIMEOUT per channel.
  - ResultTimeout is all 1. ResultDup is 0.
  - ResultStrobe, Busy and Restarted are 0.
- Input conditioning: every async input passes through 2 FFs plus a delay FF. Edge = stage2 & ~stage3. The edge pulse is 1 cycle long and appears 2 clocks after the first sampling edge that sees the input high.
- States:
  - IDLE: Count holds. Launch edges are ignored.
  - ARMED: the measurement window is open.
  - Sync edge in any state: Count <= 0, all capture/got/dup registers <= 0, state <= ARMED.
  - If a sync edge arrives while ARMED, Restarted pulses for 1 cycle. The old window is discarded and nothing is published.
- Counting in ARMED:
  - Count increments by 1 per cycle while Count < TIMEOUT.
  - The first cycle after the sync edge has Count = 0.
- Capture, channel i, on a launch edge while ARMED:
  - If got[i] = 0: cap[i] <= Count, got[i] <= 1.
  - Else: dup[i] <= 1 and cap[i] is unchanged.
- Publish condition:
  - Count == TIMEOUT while ARMED, or
  - EARLY_DONE = 1 and all got[] = 1. This includes got bits being set in the current cycle, so publish happens the cycle after the last capture.
- Publish action, registered, effective next cycle:
  - ResultTimer[i] <= got[i] ? cap[i] : TIMEOUT
  - ResultTimeout[i] <= ~got[i]
  - ResultDup[i] <= dup[i]
  - ResultStrobe <= 1 for exactly one cycle
  - state <= IDLE, Busy <= 0
- A launch edge in the same cycle as Count == TIMEOUT is still captured and published with value TIMEOUT.
- Simultaneous sync edge and launch edge in one cycle: sync wins and the launch is ignored.
- Simultaneous sync edge and publish condition in one cycle: sync wins and there is no publish. Restarted pulses.
- Between strobes, Result* outputs hold their values.
- Busy = (state == ARMED), registered.
- Reset asserted mid-window: immediate return to reset values. No strobe is produced.

Test Plan:
1. Sync edge, launch ch0 after 10 cycles, ch1 after 50, ch2 after 126; ch3 silent (N_CH=4, CNT_W=8, TIMEOUT=127, EARLY_DONE=0) -> a single strobe appears 128 cycles after the sync edge pulse. ResultTimer = {127, 126, 50, 10}. ResultTimeout = 4'b1000. ResultDup = 0.
2. EARLY_DONE=1, all 4 channels launch at Count=20 -> strobe on the cycle after the capture. Each ResultTimer = 20. Busy falls with the strobe.
3. Channel 1 launches at Count=5 and again at 30 -> ResultTimer[1] = 5 and ResultDup = 4'b0010.
4. Second sync edge at Count=60, then ch0 launches 7 cycles later -> Restarted pulses once. There is no strobe for the first window. The next publish gives ResultTimer[0] = 7.
5. Launch edges while IDLE, and a launch edge coincident with the sync edge pulse -> ignored. That channel reports Timeout = 1 and value 127.
6. nReset pulled low at Count=40, then released -> outputs return to reset values immediately. No strobe occurs until a new sync window completes.
